multi_digit_display: RTL

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/multi_digit_display.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_display
//  Description : Multiplexed 7-segment driver showing an unsigned value in hex
//                or decimal (double-dabble), with leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_display #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  decimal_mode,
    input  logic                  blank_zeros,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    // k BCD digits always hold 3k binary bits, since 8^k < 10^k
    localparam int c_BCD_DIGITS = (DATA_WIDTH + 2) / 3;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_DD_W       = c_BCD_W + DATA_WIDTH;
    localparam int c_DISP_W     = 4 * NUM_DIGITS;
    localparam int c_CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int c_REF_W      = $clog2(REFRESH_DIV);
    localparam int c_IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0]    c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_REF_W-1:0]    c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);
    localparam logic [6:0]            c_SEG_OFF  = 7'b1111111;
    localparam logic [6:0]            c_SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_cap_value;
    logic                    r_cap_dec;
    logic                    r_cap_valid;
    logic [c_DD_W-1:0]       r_dd;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [c_DISP_W-1:0]     r_disp;
    logic                    r_dash;
    logic [c_REF_W-1:0]      r_ref_cnt;
    logic [c_IDX_W-1:0]      r_scan_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [c_DD_W-1:0]       w_dd_adj;
    logic [c_BCD_W-1:0]      w_bcd;
    logic                    w_ovf;
    logic                    w_zero_above;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        case (d)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Double-dabble correction applied before each left shift
    always_comb begin
        w_dd_adj = r_dd;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            if (r_dd[DATA_WIDTH + 4*i +: 4] >= 4'd5)
                w_dd_adj[DATA_WIDTH + 4*i +: 4] = r_dd[DATA_WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd = r_dd[c_DD_W-1 -: c_BCD_W];

    always_comb begin
        w_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < c_BCD_DIGITS; i++)
            w_ovf = w_ovf | (w_bcd[4*i +: 4] != 4'd0);
    end

    // A fresh capture is required after every conversion so stale inputs never relaunch one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cap_value <= '0;
            r_cap_dec   <= 1'b0;
            r_cap_valid <= 1'b0;
            r_dd        <= '0;
            r_bit_cnt   <= '0;
            r_disp      <= '0;
            r_dash      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cap_value <= value;
                    r_cap_dec   <= decimal_mode;
                    r_cap_valid <= 1'b1;
                    if (r_cap_valid) begin
                        if (r_cap_dec) begin
                            r_dd        <= c_DD_W'(r_cap_value);
                            r_bit_cnt   <= '0;
                            r_cap_valid <= 1'b0;
                            r_state     <= S_SHIFT;
                        end else begin
                            r_disp <= c_DISP_W'(r_cap_value);
                            r_dash <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_dd      <= w_dd_adj << 1;
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    if (r_bit_cnt == c_LAST_BIT)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_disp  <= c_DISP_W'(w_bcd);
                    r_dash  <= w_ovf;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= '0;
        end else if (r_ref_cnt == c_REF_LAST) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + c_IDX_W'(1);
        end else begin
            r_ref_cnt  <= r_ref_cnt + c_REF_W'(1);
        end
    end

    // Digit i blanks when it and every digit above it are zero; digit 0 never blanks
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_disp[4*i +: 4] == 4'd0);
            w_blank[i]   = blank_zeros & w_zero_above & (i != 0) & ~r_dash;
        end
    end

    always_comb begin
        w_cur_digit = 4'd0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == c_IDX_W'(i)) begin
                w_cur_digit = r_disp[4*i +: 4];
                w_cur_blank = w_blank[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= c_SEG_OFF;
            r_an  <= '1;
        end else begin
            r_an <= ~(c_AN_ONE << r_scan_idx);
            if (r_dash)
                r_seg <= c_SEG_DASH;
            else if (w_cur_blank)
                r_seg <= c_SEG_OFF;
            else
                r_seg <= hex_to_seg(w_cur_digit);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire
